// File: rtl/pipe_hazard_ctrl_if.sv
// Bundles the hazard controller's pipeline status inputs and stage-control outputs.
// No latency of its own; it only groups the wires.
// No backpressure of its own; stalls are expressed through the *_wen/flush controls.
interface pipe_hazard_ctrl_if #(
    parameter int REG_W = 3,
    parameter int CNT_W = 16
);
    // Pipeline status seen by the controller
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic             id_halt;
    logic [REG_W-1:0] ex_rd;
    logic             ex_memread;
    logic             ex_branch_taken;
    logic             imem_stall;
    logic             dmem_stall;
    logic             wb_halt;

    // Stage controls driven by the controller
    logic             pc_wen;
    logic             ifid_wen;
    logic             ifid_flush;
    logic             idex_wen;
    logic             idex_flush;
    logic             exmem_wen;
    logic             memwb_wen;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;

    // Pipeline datapath side: reports status, obeys controls
    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_halt,
        output ex_rd, ex_memread, ex_branch_taken,
        output imem_stall, dmem_stall, wb_halt,
        input  pc_wen, ifid_wen, ifid_flush, idex_wen, idex_flush,
        input  exmem_wen, memwb_wen, halted, stall_cnt
    );

    // Hazard controller side
    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_halt,
        input  ex_rd, ex_memread, ex_branch_taken,
        input  imem_stall, dmem_stall, wb_halt,
        output pc_wen, ifid_wen, ifid_flush, idex_wen, idex_flush,
        output exmem_wen, memwb_wen, halted, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline (load-use, branch flush, mem stalls, halt drain).
// Stage controls are combinational from state and inputs (zero latency); state and counter update each edge.
// dmem_stall freezes every stage; imem_stall and load-use hold fetch while older stages keep moving.
module pipe_hazard_ctrl #(
    parameter int REG_W = 3,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pipe_hazard_ctrl_if.slave      bus
);

    // RUN: normal flow; DRAIN: HALT has left ID and fetch is frozen; HALTED: terminal until reset
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    logic load_use;
    logic rs_hit;
    logic rt_hit;

    logic pc_wen;
    logic ifid_wen;
    logic ifid_flush;
    logic idex_wen;
    logic idex_flush;
    logic exmem_wen;
    logic memwb_wen;

    // Load in EX whose destination feeds the instruction in ID; register 0 is compared like any other
    always_comb begin
        rs_hit   = bus.id_use_rs && (bus.ex_rd == bus.id_rs);
        rt_hit   = bus.id_use_rt && (bus.ex_rd == bus.id_rt);
        load_use = bus.ex_memread && (rs_hit || rt_hit);
    end

    // Next state and stage controls, resolved in hazard priority order
    always_comb begin
        state_d    = state_q;
        pc_wen     = 1'b1;
        ifid_wen   = 1'b1;
        ifid_flush = 1'b0;
        idex_wen   = 1'b1;
        idex_flush = 1'b0;
        exmem_wen  = 1'b1;
        memwb_wen  = 1'b1;

        unique case (state_q)
            ST_RUN: begin
                if (bus.dmem_stall) begin
                    // Data memory busy: nothing may move, nothing is squashed
                    pc_wen    = 1'b0;
                    ifid_wen  = 1'b0;
                    idex_wen  = 1'b0;
                    exmem_wen = 1'b0;
                    memwb_wen = 1'b0;
                end else if (bus.ex_branch_taken) begin
                    // Redirect fetch and kill the two wrong-path instructions behind the branch
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (load_use) begin
                    // Hold PC and IF/ID one cycle and slip a single bubble into EX
                    pc_wen     = 1'b0;
                    ifid_wen   = 1'b0;
                    idex_flush = 1'b1;
                end else if (bus.imem_stall) begin
                    // Fetch has nothing valid: keep PC, feed a NOP downstream
                    pc_wen     = 1'b0;
                    ifid_flush = 1'b1;
                end

                // HALT only leaves ID on a cycle where ID/EX actually takes it unflushed
                if (bus.id_halt && !bus.dmem_stall && !bus.ex_branch_taken && !load_use) begin
                    state_d = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                if (bus.dmem_stall) begin
                    pc_wen    = 1'b0;
                    ifid_wen  = 1'b0;
                    idex_wen  = 1'b0;
                    exmem_wen = 1'b0;
                    memwb_wen = 1'b0;
                end else if (bus.ex_branch_taken) begin
                    // The HALT was speculative; squash it and resume fetch at the target
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else begin
                    // Fetch frozen, NOPs enter behind HALT while it walks to writeback
                    pc_wen     = 1'b0;
                    ifid_flush = 1'b1;
                end

                // HALT reaching writeback is final; otherwise a taken branch cancels the drain
                if (bus.wb_halt) begin
                    state_d = ST_HALTED;
                end else if (!bus.dmem_stall && bus.ex_branch_taken) begin
                    state_d = ST_RUN;
                end
            end

            ST_HALTED: begin
                pc_wen    = 1'b0;
                ifid_wen  = 1'b0;
                idex_wen  = 1'b0;
                exmem_wen = 1'b0;
                memwb_wen = 1'b0;
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Saturating count of fetch-stalled cycles, frozen once the core has halted
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_wen && (state_q != ST_HALTED) && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Sequencer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Stall counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.pc_wen     = pc_wen;
    assign bus.ifid_wen   = ifid_wen;
    assign bus.ifid_flush = ifid_flush;
    assign bus.idex_wen   = idex_wen;
    assign bus.idex_flush = idex_flush;
    assign bus.exmem_wen  = exmem_wen;
    assign bus.memwb_wen  = memwb_wen;
    assign bus.halted     = (state_q == ST_HALTED);
    assign bus.stall_cnt  = stall_cnt_q;

endmodule
